// File: rtl/sccb_if.sv
// SCCB master request/response and pad-enable bundle.
// Pad enables are pull-low: 1 drives the line low, 0 releases it.
interface sccb_if;
  logic        start;
  logic        rw;
  logic [15:0] reg_addr;
  logic [7:0]  wdata;
  logic        SIOD_in;
  logic        ready;
  logic [7:0]  rdata;
  logic        rdata_valid;
  logic        nack_err;
  logic        SIOC_oe;
  logic        SIOD_oe;

  modport master (
    input  start, rw, reg_addr, wdata, SIOD_in,
    output ready, rdata, rdata_valid, nack_err, SIOC_oe, SIOD_oe
  );

  modport slave (
    output start, rw, reg_addr, wdata, SIOD_in,
    input  ready, rdata, rdata_valid, nack_err, SIOC_oe, SIOD_oe
  );
endinterface

// File: rtl/sccb_master.sv
// SCCB master: 3-phase write, 2-phase write + 2-phase read, 8/16-bit register address.
// Optional macro SCCB_ACK_CHECK_EN: sample slave ACK on master-sent bytes, abort on NACK.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | ready, lines released
// S_START  | SIOD low while SIOC released (also entry point for restart)
// (LOAD)   | zero-cycle byte pick on exit from START and after each 9th bit
// S_BIT_LO | SIOC low, SIOD held
// S_BIT_SET| SIOC low, SIOD set to the data bit (released for read/9th bit)
// S_BIT_HI | SIOC released for 2Q, sample point at Q
// S_STOP1  | SIOC low, SIOD low
// S_STOP2  | SIOC released, SIOD low
// S_STOP3  | SIOD released (STOP edge)
// S_GAP    | idle spacing, then IDLE or read phase 2
module sccb_master #(
  parameter int         CLK_FREQ       = 25_000_000,
  parameter int         SCCB_FREQ      = 100_000,
  parameter logic [7:0] DEV_ADDR       = 8'h42,
  parameter int         REG_ADDR_BYTES = 1,
  parameter int         GAP_Q          = 8
) (
  input logic    clk,
  input logic    reset,
  sccb_if.master bus
);
  localparam int Q    = CLK_FREQ / (4 * SCCB_FREQ);
  localparam int TMAX = (GAP_Q * Q > 2 * Q) ? GAP_Q * Q : 2 * Q;
  localparam int TW   = $clog2(TMAX + 2);
  localparam logic [TW-1:0] T_Q   = TW'(Q - 1);
  localparam logic [TW-1:0] T_2Q  = TW'(2 * Q - 1);
  localparam logic [TW-1:0] T_GAP = TW'(GAP_Q * Q - 1);

  if (Q < 1) begin : g_q_chk
    $error("sccb_master: CLK_FREQ/(4*SCCB_FREQ) must be at least 1");
  end
  if (REG_ADDR_BYTES != 1 && REG_ADDR_BYTES != 2) begin : g_rab_chk
    $error("sccb_master: REG_ADDR_BYTES must be 1 or 2");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_BIT_LO, S_BIT_SET, S_BIT_HI, S_STOP1, S_STOP2, S_STOP3, S_GAP
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    byte_idx, byte_idx_n;
  logic [3:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic [6:0]    rx, rx_n;
  logic [7:0]    rdata_q, rdata_n;
  logic          rdata_valid_q, rdata_valid_n;
  logic          nack_q, nack_n;
  logic          abort, abort_n;
  logic          phase2, phase2_n;
  logic          rw_q, rw_n;
  logic [15:0]   addr_q, addr_n;
  logic [7:0]    wdata_q, wdata_n;
  logic          sioc_q, sioc_n;
  logic          siod_q, siod_n;

  logic       tdone, rd_byte, load, ack_fail;
  logic [2:0] nbytes;
  logic [7:0] next_byte;

`ifdef SCCB_ACK_CHECK_EN
  assign ack_fail     = bus.SIOD_in;
  assign bus.nack_err = nack_q;
`else
  assign ack_fail     = 1'b0;
  assign bus.nack_err = 1'b0;
`endif

  assign tdone   = (timer == '0);
  assign rd_byte = phase2 && (byte_idx == 3'd2);
  assign nbytes  = phase2 ? 3'd2 : (rw_q ? 3'(1 + REG_ADDR_BYTES) : 3'(2 + REG_ADDR_BYTES));

  always_comb begin
    next_byte = wdata_q;
    if (phase2)
      next_byte = (byte_idx == 3'd0) ? (DEV_ADDR | 8'h01) : 8'h00;
    else if (byte_idx == 3'd0)
      next_byte = DEV_ADDR;
    else if (REG_ADDR_BYTES == 2 && byte_idx == 3'd1)
      next_byte = addr_q[15:8];
    else if (byte_idx == 3'(REG_ADDR_BYTES))
      next_byte = addr_q[7:0];
  end

  always_comb begin
    state_n       = state;
    timer_n       = tdone ? timer : timer - 1'b1;
    byte_idx_n    = byte_idx;
    bit_cnt_n     = bit_cnt;
    shreg_n       = shreg;
    rx_n          = rx;
    rdata_n       = rdata_q;
    rdata_valid_n = 1'b0;
    nack_n        = nack_q;
    abort_n       = abort;
    phase2_n      = phase2;
    rw_n          = rw_q;
    addr_n        = addr_q;
    wdata_n       = wdata_q;
    sioc_n        = sioc_q;
    siod_n        = siod_q;
    load          = 1'b0;

    case (state)
      S_IDLE: if (bus.start) begin
        rw_n       = bus.rw;
        addr_n     = bus.reg_addr;
        wdata_n    = bus.wdata;
        nack_n     = 1'b0;
        abort_n    = 1'b0;
        phase2_n   = 1'b0;
        byte_idx_n = '0;
        siod_n     = 1'b1;
        timer_n    = T_Q;
        state_n    = S_START;
      end
      S_START: load = tdone;
      S_BIT_LO: if (tdone) begin
        siod_n  = (bit_cnt == 4'd8 || rd_byte) ? 1'b0 : ~shreg[7];
        timer_n = T_Q;
        state_n = S_BIT_SET;
      end
      S_BIT_SET: if (tdone) begin
        sioc_n  = 1'b0;
        timer_n = T_2Q;
        state_n = S_BIT_HI;
      end
      S_BIT_HI: begin
        if (timer == T_Q) begin
          if (rd_byte && bit_cnt != 4'd8) begin
            rx_n = {rx[5:0], bus.SIOD_in};
            if (bit_cnt == 4'd7) begin
              rdata_n       = {rx, bus.SIOD_in};
              rdata_valid_n = 1'b1;
            end
          end else if (!rd_byte && bit_cnt == 4'd8 && ack_fail) begin
            nack_n  = 1'b1;
            abort_n = 1'b1;
          end
        end
        if (tdone) begin
          if (bit_cnt == 4'd8) begin
            load = 1'b1;
          end else begin
            sioc_n    = 1'b1;
            shreg_n   = {shreg[6:0], 1'b0};
            bit_cnt_n = bit_cnt + 1'b1;
            timer_n   = T_Q;
            state_n   = S_BIT_LO;
          end
        end
      end
      S_STOP1: if (tdone) begin
        sioc_n  = 1'b0;
        timer_n = T_Q;
        state_n = S_STOP2;
      end
      S_STOP2: if (tdone) begin
        siod_n  = 1'b0;
        timer_n = T_Q;
        state_n = S_STOP3;
      end
      S_STOP3: if (tdone) begin
        timer_n = T_GAP;
        state_n = S_GAP;
      end
      S_GAP: if (tdone) begin
        // A read continues with its second phase unless phase 1 was NACKed
        if (rw_q && !phase2 && !abort) begin
          phase2_n   = 1'b1;
          byte_idx_n = '0;
          siod_n     = 1'b1;
          timer_n    = T_Q;
          state_n    = S_START;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (load) begin
      sioc_n  = 1'b1;
      timer_n = T_Q;
      if (abort_n || byte_idx == nbytes) begin
        siod_n  = 1'b1;
        state_n = S_STOP1;
      end else begin
        shreg_n    = next_byte;
        bit_cnt_n  = '0;
        byte_idx_n = byte_idx + 1'b1;
        state_n    = S_BIT_LO;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      timer         <= '0;
      byte_idx      <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      rx            <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      nack_q        <= 1'b0;
      abort         <= 1'b0;
      phase2        <= 1'b0;
      rw_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      sioc_q        <= 1'b0;
      siod_q        <= 1'b0;
    end else begin
      state         <= state_n;
      timer         <= timer_n;
      byte_idx      <= byte_idx_n;
      bit_cnt       <= bit_cnt_n;
      shreg         <= shreg_n;
      rx            <= rx_n;
      rdata_q       <= rdata_n;
      rdata_valid_q <= rdata_valid_n;
      nack_q        <= nack_n;
      abort         <= abort_n;
      phase2        <= phase2_n;
      rw_q          <= rw_n;
      addr_q        <= addr_n;
      wdata_q       <= wdata_n;
      sioc_q        <= sioc_n;
      siod_q        <= siod_n;
    end
  end

  assign bus.ready       = (state == S_IDLE);
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.SIOC_oe     = sioc_q;
  assign bus.SIOD_oe     = siod_q;
endmodule

// File: tb/tb_sccb_master.sv
// Directed bench for sccb_master: dut0 uses 8-bit register addresses, dut1 16-bit.
// A bus monitor decodes START/STOP/bytes into a string log and plays the camera slave.
module tb_sccb_master;
  logic clk;
  logic reset;
  int   passed;
  int   total;

  sccb_if if0 ();
  sccb_if if1 ();

  sccb_master #(.CLK_FREQ(800_000), .SCCB_FREQ(100_000), .DEV_ADDR(8'h42),
                .REG_ADDR_BYTES(1), .GAP_Q(8))
    dut0 (.clk(clk), .reset(reset), .bus(if0));

  sccb_master #(.CLK_FREQ(800_000), .SCCB_FREQ(100_000), .DEV_ADDR(8'h42),
                .REG_ADDR_BYTES(2), .GAP_Q(8))
    dut1 (.clk(clk), .reset(reset), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor / slave state, one slot per DUT
  string      mlog [2];
  int         bitn [2];
  int         bytn [2];
  int         ninth_bad [2];
  int         rv_cnt [2];
  logic [7:0] cur [2];
  logic       pull [2];
  logic       pc [2];
  logic       pd [2];
  logic       isrd [2];
  logic [7:0] rd_val;
  logic       nack_on;
  int         nack_byte;

  assign if0.SIOD_in = ~if0.SIOD_oe & ~pull[0];
  assign if1.SIOD_in = ~if1.SIOD_oe & ~pull[1];

  task automatic mon_clear(input int k);
    mlog[k] = "";
    bitn[k] = 0;
    bytn[k] = 0;
    cur[k]  = 8'h00;
    pull[k] = 1'b0;
    pc[k]   = 1'b0;
    pd[k]   = 1'b0;
    isrd[k] = 1'b0;
  endtask

  task automatic mon(input int k, input logic c, input logic d, input logic rv);
    logic line;
    line = ~d & ~pull[k];
    if (rv === 1'b1) rv_cnt[k]++;
    if (c === 1'b0 && pc[k] === 1'b0 && d === 1'b1 && pd[k] === 1'b0) begin
      mlog[k] = {mlog[k], "S"};
      bitn[k] = 0;
      bytn[k] = 0;
      pull[k] = 1'b0;
    end else if (c === 1'b0 && pc[k] === 1'b0 && d === 1'b0 && pd[k] === 1'b1) begin
      mlog[k] = {mlog[k], "P"};
    end else if (c === 1'b1 && pc[k] === 1'b0) begin
      // SIOC just went low: slave sets up the next bit
      if (bitn[k] == 8)
        pull[k] = !(isrd[k] && bytn[k] == 1) && !(nack_on && bytn[k] == nack_byte);
      else if (isrd[k] && bytn[k] == 1)
        pull[k] = ~rd_val[7 - bitn[k]];
      else
        pull[k] = 1'b0;
    end else if (c === 1'b0 && pc[k] === 1'b1) begin
      if (bitn[k] == 8) begin
        if (d !== 1'b0) ninth_bad[k]++;
        mlog[k] = {mlog[k], $sformatf("%h", cur[k])};
        bitn[k] = 0;
        bytn[k]++;
      end else begin
        cur[k] = {cur[k][6:0], line};
        bitn[k]++;
        if (bitn[k] == 8 && bytn[k] == 0) isrd[k] = cur[k][0];
      end
    end
    pc[k] = c;
    pd[k] = d;
  endtask

  always @(negedge clk) begin
    mon(0, if0.SIOC_oe, if0.SIOD_oe, if0.rdata_valid);
    mon(1, if1.SIOC_oe, if1.SIOD_oe, if1.rdata_valid);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_log(input int k, input string tag, input string exp);
    total++;
    assert (mlog[k].compare(exp) === 0) passed++;
    else $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, mlog[k], exp);
  endtask

  function automatic logic rdy(input int k);
    return (k == 0) ? if0.ready : if1.ready;
  endfunction

  // Request one transaction; returns at the negedge after the accepting edge
  task automatic go(input int k, input logic rwv, input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    if (k == 0) begin
      if0.start = 1'b1; if0.rw = rwv; if0.reg_addr = a; if0.wdata = d;
    end else begin
      if1.start = 1'b1; if1.rw = rwv; if1.reg_addr = a; if1.wdata = d;
    end
    @(negedge clk);
    if0.start = 1'b0;
    if1.start = 1'b0;
  endtask

  task automatic wait_ready(input int k, output int lat);
    lat = 0;
    while (rdy(k) !== 1'b1 && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    passed = 0;
    total  = 0;
    reset  = 1'b1;
    if0.start = 1'b0; if0.rw = 1'b0; if0.reg_addr = '0; if0.wdata = '0;
    if1.start = 1'b0; if1.rw = 1'b0; if1.reg_addr = '0; if1.wdata = '0;
    rd_val    = 8'h00;
    nack_on   = 1'b0;
    nack_byte = 1;
    ninth_bad[0] = 0; ninth_bad[1] = 0;
    rv_cnt[0] = 0; rv_cnt[1] = 0;
    mon_clear(0);
    mon_clear(1);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_ready", if0.ready, 1);
    check("rst_sioc", if0.SIOC_oe, 0);
    check("rst_siod", if0.SIOD_oe, 0);
    check("rst_rdata", if0.rdata, 8'h00);
    check("rst_rvalid", if0.rdata_valid, 0);
    check("rst_nack", if0.nack_err, 0);

    // 8-bit address write: START + 27 bits + STOP + GAP = 2+216+6+16
    go(0, 1'b0, 16'h0012, 8'h80);
    check("wr8_busy", if0.ready, 0);
    wait_ready(0, lat);
    check("wr8_latency", lat, 240);
    check_log(0, "wr8_bytes", "S421280P");

    // 16-bit address write: 2+36*8+6+16
    go(1, 1'b0, 16'h3008, 8'h82);
    wait_ready(1, lat);
    check("wr16_latency", lat, 312);
    check_log(1, "wr16_bytes", "S42300882P");

    // Read: two 168-clock phases, slave returns 0x76
    mon_clear(0);
    rd_val    = 8'h76;
    rv_cnt[0] = 0;
    go(0, 1'b1, 16'h000A, 8'h00);
    wait_ready(0, lat);
    check("rd_latency", lat, 336);
    check_log(0, "rd_bytes", "S420aPS4376P");
    check("rd_rdata", if0.rdata, 8'h76);
    check("rd_valid_pulses", rv_cnt[0], 1);

    // start held high: back-to-back with one ready cycle, wdata latched per transaction
    mon_clear(0);
    @(negedge clk);
    if0.start = 1'b1; if0.rw = 1'b0; if0.reg_addr = 16'h0012; if0.wdata = 8'h80;
    @(negedge clk);
    if0.wdata = 8'h55;
    wait_ready(0, lat);
    check("b2b_lat1", lat, 240);
    @(negedge clk);
    check("b2b_accept", if0.ready, 0);
    if0.start = 1'b0;
    wait_ready(0, lat);
    check("b2b_lat2", lat, 240);
    check_log(0, "b2b_bytes", "S421280PS421255P");
    check("rdata_hold", if0.rdata, 8'h76);
    check("rvalid_none", rv_cnt[0], 1);

    // Reset in the middle of byte 2 together with a start request
    go(0, 1'b0, 16'h0012, 8'h80);
    repeat (100) @(negedge clk);
    check("pre_rst_busy", if0.ready, 0);
    reset = 1'b1;
    if0.start = 1'b1;
    @(negedge clk);
    check("midrst_sioc", if0.SIOC_oe, 0);
    check("midrst_siod", if0.SIOD_oe, 0);
    check("midrst_ready", if0.ready, 1);
    check("midrst_rdata", if0.rdata, 8'h00);
    reset = 1'b0;
    if0.start = 1'b0;
    @(posedge clk);
    #1 mon_clear(0);
    @(negedge clk);
    check("midrst_start_dropped", if0.ready, 1);
    go(0, 1'b0, 16'h0033, 8'h5A);
    wait_ready(0, lat);
    check("post_rst_latency", lat, 240);
    check_log(0, "post_rst_bytes", "S42335aP");

`ifdef SCCB_ACK_CHECK_EN
    // Slave NACKs the register-address byte: abort after 2 bytes, 2+18*8+6+16
    mon_clear(0);
    nack_on   = 1'b1;
    nack_byte = 1;
    go(0, 1'b0, 16'h0012, 8'h80);
    wait_ready(0, lat);
    check("nack_latency", lat, 168);
    check_log(0, "nack_bytes", "S4212P");
    check("nack_flag", if0.nack_err, 1);
    nack_on = 1'b0;
    go(0, 1'b0, 16'h0012, 8'h80);
    check("nack_cleared", if0.nack_err, 0);
    wait_ready(0, lat);
    check("ack_latency", lat, 240);
`endif

    check("ninth_released0", ninth_bad[0], 0);
    check("ninth_released1", ninth_bad[1], 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
